// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RETI sequencer: pushes PC+PSW, fetches the vector, updates SR/SP/PC.
// Optional feature macro: SLEEP_WAKE_EN (masked IRQ wakes a sleeping core without entry).
module interrupt_sequencer #(
  parameter int              WORD         = 16,
  parameter int              FLAGS        = 4,
  parameter int              PLVLS        = 8,
  parameter int              VECTORS      = 8,
  parameter logic [WORD-1:0] VECBASE      = 16'hFFC0,
  parameter int              HANDLER_PRIV = 0
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic [VECTORS-1:0]       irq_i,
  input  logic                     instrBoundary_i,
  input  logic                     reti_i,
  input  logic [WORD-1:0]          psw_i,
  input  logic                     ie_i,
  input  logic                     slp_i,
  input  logic [WORD-1:0]          pc_i,
  input  logic [WORD-1:0]          sp_i,
  output logic                     busy_o,
  output logic [VECTORS-1:0]       irqAck_o,
  output logic                     srWrEn_o,
  output logic                     srClrSlp_o,
  output logic                     srSetPriv_o,
  output logic [WORD/8-1:0]        srWrMode_o,
  output logic [WORD-1:0]          srData_o,
  output logic [$clog2(PLVLS)-1:0] srPriv_o,
  output logic                     pcWr_o,
  output logic                     spWr_o,
  output logic [WORD-1:0]          pcData_o,
  output logic [WORD-1:0]          spData_o,
  output logic                     memReq_o,
  output logic                     memWr_o,
  output logic [WORD-1:0]          memAddr_o,
  output logic [WORD-1:0]          memWData_o,
  input  logic                     memAck_i,
  input  logic [WORD-1:0]          memRData_i,
  output logic [3:0]               dbg_state_o
);

  localparam int              PRIVW = $clog2(PLVLS);
  localparam int              IDXW  = (VECTORS > 1) ? $clog2(VECTORS) : 1;
  localparam int              BYTES = WORD / 8;
  localparam logic [WORD-1:0] TWO   = WORD'(2);
  localparam logic [WORD-1:0] FOUR  = WORD'(4);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PUSH_PC   = 4'd1,
    PUSH_PSW  = 4'd2,
    FETCH_VEC = 4'd3,
    SR_CLR    = 4'd4,
    SET_PRIV  = 4'd5,
    POP_PSW   = 4'd6,
    POP_PC    = 4'd7,
    RESTORE   = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [WORD-1:0]   r_sp;
  logic [WORD-1:0]   r_pc;
  logic [WORD-1:0]   r_psw;
  logic [WORD-1:0]   r_vec;
  logic [WORD-1:0]   r_pop_psw;
  logic [WORD-1:0]   r_pop_pc;

  logic [IDXW-1:0]   w_idx;
  logic              w_any_irq;
  logic              w_take_irq;
  logic [WORD-1:0]   w_psw_clr;
  logic [WORD-1:0]   w_vec_addr;

  // Lowest set request line wins.
  always_comb begin
    w_idx = '0;
    for (int i = VECTORS - 1; i >= 0; i--) begin
      if (irq_i[i]) w_idx = IDXW'(i);
    end
  end

  assign w_any_irq  = |irq_i;
  assign w_take_irq = instrBoundary_i && ie_i && w_any_irq;
  assign w_vec_addr = VECBASE + {{(WORD-IDXW-1){1'b0}}, r_idx, 1'b0};

  always_comb begin
    w_psw_clr            = r_psw;
    w_psw_clr[FLAGS]     = 1'b0;
    w_psw_clr[FLAGS + 1] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // RETI wins over a simultaneous interrupt; the level request is taken afterwards.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (reti_i)          w_state_nxt = POP_PSW;
        else if (w_take_irq) w_state_nxt = PUSH_PC;
      end
      PUSH_PC:   if (memAck_i) w_state_nxt = PUSH_PSW;
      PUSH_PSW:  if (memAck_i) w_state_nxt = FETCH_VEC;
      FETCH_VEC: if (memAck_i) w_state_nxt = SR_CLR;
      SR_CLR:    w_state_nxt = SET_PRIV;
      SET_PRIV:  w_state_nxt = IDLE;
      POP_PSW:   if (memAck_i) w_state_nxt = POP_PC;
      POP_PC:    if (memAck_i) w_state_nxt = RESTORE;
      RESTORE:   w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_idx     <= '0;
      r_sp      <= '0;
      r_pc      <= '0;
      r_psw     <= '0;
      r_vec     <= '0;
      r_pop_psw <= '0;
      r_pop_pc  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (reti_i) begin
            r_sp <= sp_i;
          end else if (w_take_irq) begin
            r_idx <= w_idx;
            r_sp  <= sp_i;
            r_pc  <= pc_i;
            r_psw <= psw_i;
          end
        end
        FETCH_VEC: if (memAck_i) r_vec     <= memRData_i;
        POP_PSW:   if (memAck_i) r_pop_psw <= memRData_i;
        POP_PC:    if (memAck_i) r_pop_pc  <= memRData_i;
        default: ;
      endcase
    end
  end

  // Memory handshake: memReq_o, memWr_o, memAddr_o and memWData_o are decoded from
  // state and latched values only, so they hold steady until the edge with memAck_i=1,
  // which completes the transfer; memRData_i is captured on that same edge.
  always_comb begin
    busy_o      = (r_state != IDLE);
    irqAck_o    = '0;
    srWrEn_o    = 1'b0;
    srSetPriv_o = 1'b0;
    srWrMode_o  = '0;
    srData_o    = '0;
    srPriv_o    = '0;
    pcWr_o      = 1'b0;
    spWr_o      = 1'b0;
    pcData_o    = '0;
    spData_o    = '0;
    memReq_o    = 1'b0;
    memWr_o     = 1'b0;
    memAddr_o   = '0;
    memWData_o  = '0;
    case (r_state)
      PUSH_PC: begin
        memReq_o   = 1'b1;
        memWr_o    = 1'b1;
        memAddr_o  = r_sp - TWO;
        memWData_o = r_pc;
      end
      PUSH_PSW: begin
        memReq_o   = 1'b1;
        memWr_o    = 1'b1;
        memAddr_o  = r_sp - FOUR;
        memWData_o = r_psw;
      end
      FETCH_VEC: begin
        memReq_o  = 1'b1;
        memAddr_o = w_vec_addr;
      end
      SR_CLR: begin
        srWrEn_o   = 1'b1;
        srWrMode_o = BYTES'(1);
        srData_o   = w_psw_clr;
        spWr_o     = 1'b1;
        spData_o   = r_sp - FOUR;
      end
      SET_PRIV: begin
        srSetPriv_o     = 1'b1;
        srPriv_o        = PRIVW'(HANDLER_PRIV);
        pcWr_o          = 1'b1;
        pcData_o        = r_vec;
        irqAck_o[r_idx] = 1'b1;
      end
      POP_PSW: begin
        memReq_o  = 1'b1;
        memAddr_o = r_sp;
      end
      POP_PC: begin
        memReq_o  = 1'b1;
        memAddr_o = r_sp + TWO;
      end
      RESTORE: begin
        srWrEn_o   = 1'b1;
        srWrMode_o = '1;
        srData_o   = r_pop_psw;
        pcWr_o     = 1'b1;
        pcData_o   = r_pop_pc;
        spWr_o     = 1'b1;
        spData_o   = r_sp + FOUR;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = r_state;

`ifdef SLEEP_WAKE_EN
  logic r_clr_slp;

  // SLP is still visible the cycle after the pulse, so the pulse blocks its own repeat.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_clr_slp <= 1'b0;
    end else begin
      r_clr_slp <= (r_state == IDLE) && !reti_i && slp_i && !ie_i && w_any_irq && !r_clr_slp;
    end
  end

  assign srClrSlp_o = r_clr_slp;
`else
  logic w_unused_slp;

  assign w_unused_slp = slp_i;
  assign srClrSlp_o   = 1'b0;
`endif

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry, RETI, collision, wait states, wrap,
// masking/wake and asynchronous reset, with a memory responder and transfer scoreboard.
module tb_interrupt_sequencer;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [7:0]  irq_i;
  logic        instrBoundary_i, reti_i, ie_i, slp_i;
  logic [15:0] psw_i, pc_i, sp_i;
  logic        busy_o;
  logic [7:0]  irqAck_o;
  logic        srWrEn_o, srClrSlp_o, srSetPriv_o;
  logic [1:0]  srWrMode_o;
  logic [15:0] srData_o;
  logic [2:0]  srPriv_o;
  logic        pcWr_o, spWr_o;
  logic [15:0] pcData_o, spData_o;
  logic        memReq_o, memWr_o;
  logic [15:0] memAddr_o, memWData_o;
  logic        memAck_i;
  logic [15:0] memRData_i;
  logic [3:0]  dbg_state_o;

`ifdef SLEEP_WAKE_EN
  localparam int EXP_WAKE = 1;
`else
  localparam int EXP_WAKE = 0;
`endif

  always #5 clk_i = ~clk_i;

  interrupt_sequencer dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .irq_i(irq_i), .instrBoundary_i(instrBoundary_i),
    .reti_i(reti_i), .psw_i(psw_i), .ie_i(ie_i), .slp_i(slp_i), .pc_i(pc_i), .sp_i(sp_i),
    .busy_o(busy_o), .irqAck_o(irqAck_o), .srWrEn_o(srWrEn_o), .srClrSlp_o(srClrSlp_o),
    .srSetPriv_o(srSetPriv_o), .srWrMode_o(srWrMode_o), .srData_o(srData_o),
    .srPriv_o(srPriv_o), .pcWr_o(pcWr_o), .spWr_o(spWr_o), .pcData_o(pcData_o),
    .spData_o(spData_o), .memReq_o(memReq_o), .memWr_o(memWr_o), .memAddr_o(memAddr_o),
    .memWData_o(memWData_o), .memAck_i(memAck_i), .memRData_i(memRData_i),
    .dbg_state_o(dbg_state_o)
  );

  logic [127:0] all_outs;
  assign all_outs = {27'd0, busy_o, irqAck_o, srWrEn_o, srClrSlp_o, srSetPriv_o, srWrMode_o,
                     srData_o, srPriv_o, pcWr_o, spWr_o, pcData_o, spData_o, memReq_o,
                     memWr_o, memAddr_o, memWData_o};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of memory transfers: {wr, addr, wdata (0 for reads)}.
  logic [32:0] exp_q[$];
  logic [15:0] mem [0:32767];
  int          wait_cycles = 0;
  int          wcnt = 0;
  logic [15:0] h_addr, h_wdata;
  logic        h_wr, unstable;
  logic [32:0] e;

  int          busy_cnt, sr_cnt, priv_cnt, pc_cnt, sp_cnt, ack_cnt, clr_cnt, both_cnt;
  logic [15:0] sr_data, pc_data, sp_data;
  logic [1:0]  sr_mode;
  logic [2:0]  priv_val;
  logic [7:0]  ack_val;

  task automatic clr_counts();
    busy_cnt = 0; sr_cnt = 0; priv_cnt = 0; pc_cnt = 0; sp_cnt = 0;
    ack_cnt = 0; clr_cnt = 0; both_cnt = 0;
    sr_data = '0; pc_data = '0; sp_data = '0; sr_mode = '0; priv_val = '1; ack_val = '0;
  endtask

  task automatic push_exp(input logic wr, input logic [15:0] addr, input logic [15:0] data);
    exp_q.push_back({wr, addr, data});
  endtask

  task automatic set_mem(input logic [15:0] addr, input logic [15:0] data);
    mem[addr[15:1]] = data;
  endtask

  // Memory responder, status-register model for SLP and strobe monitor, sampled on negedge.
  always @(negedge clk_i) begin
    if (busy_o) busy_cnt++;
    if (srWrEn_o) begin sr_cnt++; sr_data = srData_o; sr_mode = srWrMode_o; end
    if (srSetPriv_o) begin priv_cnt++; priv_val = srPriv_o; end
    if (pcWr_o) begin pc_cnt++; pc_data = pcData_o; end
    if (spWr_o) begin sp_cnt++; sp_data = spData_o; end
    if (irqAck_o != 8'h00) begin ack_cnt++; ack_val = irqAck_o; end
    if (srWrEn_o && srSetPriv_o) both_cnt++;
    if (srClrSlp_o) begin clr_cnt++; slp_i = 1'b0; end
    if (memReq_o) begin
      if (wcnt == 0) begin
        h_addr = memAddr_o; h_wdata = memWData_o; h_wr = memWr_o; unstable = 1'b0;
      end else if (memAddr_o !== h_addr || memWData_o !== h_wdata || memWr_o !== h_wr) begin
        unstable = 1'b1;
      end
      if (wcnt >= wait_cycles) begin
        memAck_i = 1'b1;
        wcnt = 0;
        if (memWr_o) begin
          mem[memAddr_o[15:1]] = memWData_o;
          memRData_i = 16'h0000;
        end else begin
          memRData_i = mem[memAddr_o[15:1]];
        end
        check("mem_stable", unstable, 1'b0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check("mem_op", {memWr_o, memAddr_o, memWr_o ? memWData_o : 16'h0000}, e);
      end else begin
        memAck_i = 1'b0;
        wcnt++;
      end
    end else begin
      memAck_i = 1'b0;
      wcnt = 0;
    end
  end

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy_o) break;
      @(posedge clk_i); #1;
    end
    check("idle_timeout", busy_o, 1'b0);
  endtask

  task automatic start_entry(input logic [15:0] sp, input logic [15:0] pc,
                             input logic [15:0] psw, input logic [7:0] irq);
    @(posedge clk_i); #1;
    sp_i = sp; pc_i = pc; psw_i = psw; irq_i = irq; ie_i = 1'b1; instrBoundary_i = 1'b1;
    @(posedge clk_i); #1;
    irq_i = 8'h00; instrBoundary_i = 1'b0; ie_i = 1'b0;
  endtask

  task automatic start_reti(input logic [15:0] sp);
    @(posedge clk_i); #1;
    sp_i = sp; reti_i = 1'b1; instrBoundary_i = 1'b1;
    @(posedge clk_i); #1;
    reti_i = 1'b0; instrBoundary_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    arst_ni = 1'b0; irq_i = '0; instrBoundary_i = 0; reti_i = 0; ie_i = 0; slp_i = 0;
    psw_i = '0; pc_i = '0; sp_i = '0; memAck_i = 0; memRData_i = '0;
    clr_counts();
    set_mem(16'hFFC0, 16'h5000);
    set_mem(16'hFFC2, 16'h4100);
    set_mem(16'hFFC4, 16'h4000);
    set_mem(16'hFFCE, 16'h4700);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outs", all_outs, 128'd0);
    check("rst_state", dbg_state_o, 4'd0);
    arst_ni = 1'b1;

    // Basic entry, vector 2.
    clr_counts();
    push_exp(1, 16'h07FE, 16'h1234);
    push_exp(1, 16'h07FC, 16'h002F);
    push_exp(0, 16'hFFC4, 16'h0000);
    start_entry(16'h0800, 16'h1234, 16'h002F, 8'b0000_0100);
    wait_idle(50);
    check("ent_latency", busy_cnt, 5);
    check("ent_sr_data", sr_data, 16'h000F);
    check("ent_sr_mode", sr_mode, 2'b01);
    check("ent_sp", sp_data, 16'h07FC);
    check("ent_priv", {priv_cnt[7:0], 5'd0, priv_val}, {8'd1, 8'd0});
    check("ent_pc", pc_data, 16'h4000);
    check("ent_ack", {ack_cnt[7:0], ack_val}, {8'd1, 8'h04});
    check("ent_exclusive", both_cnt, 0);
    check("ent_q_empty", exp_q.size(), 0);

    // RETI pops what the entry pushed.
    clr_counts();
    push_exp(0, 16'h07FC, 16'h0000);
    push_exp(0, 16'h07FE, 16'h0000);
    start_reti(16'h07FC);
    wait_idle(50);
    check("reti_latency", busy_cnt, 3);
    check("reti_sr", {sr_cnt[7:0], sr_mode, sr_data}, {8'd1, 2'b11, 16'h002F});
    check("reti_pc", pc_data, 16'h1234);
    check("reti_sp", sp_data, 16'h0800);
    check("reti_no_priv_ack", {priv_cnt[7:0], ack_cnt[7:0]}, 16'd0);
    check("reti_q_empty", exp_q.size(), 0);

    // RETI and irq 0x81 together: RETI first, then vector 0.
    clr_counts();
    push_exp(0, 16'h07FC, 16'h0000);
    push_exp(0, 16'h07FE, 16'h0000);
    push_exp(1, 16'h07FA, 16'h1234);
    push_exp(1, 16'h07F8, 16'h002F);
    push_exp(0, 16'hFFC0, 16'h0000);
    @(posedge clk_i); #1;
    sp_i = 16'h07FC; pc_i = 16'h1234; psw_i = 16'h002F;
    irq_i = 8'h81; ie_i = 1'b1; instrBoundary_i = 1'b1; reti_i = 1'b1;
    @(posedge clk_i); #1;
    reti_i = 1'b0;
    check("coll_reti_first", dbg_state_o, 4'd6);
    wait_idle(50);
    @(posedge clk_i); #1;
    check("coll_entry_busy", busy_o, 1'b1);
    irq_i = 8'h00; instrBoundary_i = 1'b0; ie_i = 1'b0;
    wait_idle(50);
    check("coll_ack", {ack_cnt[7:0], ack_val}, {8'd1, 8'h01});
    check("coll_pc", pc_data, 16'h5000);
    check("coll_sr_cnt", sr_cnt, 2);
    check("coll_q_empty", exp_q.size(), 0);

    // Three wait states per access.
    clr_counts();
    wait_cycles = 3;
    push_exp(1, 16'h07FE, 16'h2222);
    push_exp(1, 16'h07FC, 16'h00FF);
    push_exp(0, 16'hFFC2, 16'h0000);
    start_entry(16'h0800, 16'h2222, 16'h00FF, 8'b0000_0010);
    wait_idle(100);
    check("ws_latency", busy_cnt, 14);
    check("ws_sr_data", sr_data, 16'h00CF);
    check("ws_pc_ack", {pc_data, ack_val}, {16'h4100, 8'h02});
    check("ws_q_empty", exp_q.size(), 0);
    wait_cycles = 0;

    // SP wrap on push (0x0000) and on pop (0xFFFC).
    clr_counts();
    push_exp(1, 16'hFFFE, 16'hABCD);
    push_exp(1, 16'hFFFC, 16'h0031);
    push_exp(0, 16'hFFCE, 16'h0000);
    start_entry(16'h0000, 16'hABCD, 16'h0031, 8'b1000_0000);
    wait_idle(50);
    check("wrap_sp", sp_data, 16'hFFFC);
    check("wrap_sr_data", sr_data, 16'h0001);
    check("wrap_pc_ack", {pc_data, ack_val}, {16'h4700, 8'h80});
    clr_counts();
    push_exp(0, 16'hFFFC, 16'h0000);
    push_exp(0, 16'hFFFE, 16'h0000);
    start_reti(16'hFFFC);
    wait_idle(50);
    check("wrap_pop_sp", sp_data, 16'h0000);
    check("wrap_pop_pc", pc_data, 16'hABCD);
    check("wrap_pop_sr", sr_data, 16'h0031);
    check("wrap_q_empty", exp_q.size(), 0);

    // IE=0 masks entry; sleeping core gets a wake pulse only when the feature is built in.
    clr_counts();
    @(posedge clk_i); #1;
    ie_i = 1'b0; slp_i = 1'b1; irq_i = 8'h01; instrBoundary_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    irq_i = 8'h00; instrBoundary_i = 1'b0; slp_i = 1'b0;
    @(posedge clk_i); #1;
    check("mask_no_entry", {busy_cnt[7:0], ack_cnt[7:0]}, 16'd0);
    check("mask_wake", clr_cnt, EXP_WAKE);

    // Asynchronous reset while fetching the vector.
    clr_counts();
    wait_cycles = 3;
    push_exp(1, 16'h07FE, 16'h3333);
    push_exp(1, 16'h07FC, 16'h0020);
    push_exp(0, 16'hFFC4, 16'h0000);
    start_entry(16'h0800, 16'h3333, 16'h0020, 8'b0000_0100);
    for (int k = 0; k < 100; k++) begin
      if (dbg_state_o == 4'd3) break;
      @(posedge clk_i); #1;
    end
    check("rst_reached_fetch", {dbg_state_o, memReq_o, memAddr_o}, {4'd3, 1'b1, 16'hFFC4});
    #1 arst_ni = 1'b0;
    #1;
    check("rst_mid_outs", all_outs, 128'd0);
    check("rst_mid_state", dbg_state_o, 4'd0);
    check("rst_mid_q", exp_q.size(), 1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1'b1;
    wait_cycles = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_after_idle", {busy_o, dbg_state_o}, 5'd0);
    check("rst_no_ack", ack_cnt, 0);
    check("final_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle sequencer that drives the write side of the status register on interrupt entry and return-from-interrupt. On entry it accepts an interrupt at an instruction boundary and pushes PC and PSW to the stack over the memory port. It then fetches the handler vector, clears IE/SLP via a byte write, and raises privilege. On return (RETI) it pops PSW and PC and restores the full status word. Sits between the control unit, the status register, the stack pointer and the data-memory port.

## Interface
- WORD, 16, datapath width; must be 16 (PSW layout fixed)
- FLAGS, 4, flag bits at PSW[FLAGS-1:0]; SLP at PSW[FLAGS], IE at PSW[FLAGS+1]
- PLVLS, 8, privilege levels; PRIVW = $clog2(PLVLS)
- VECTORS, 8, interrupt lines; index 0 has highest priority
- VECBASE, 16'hFFC0, vector table base; entry n at VECBASE + 2n
- HANDLER_PRIV, 0, privilege applied on entry

Ports:
- clk_i  in  1  clock; all state on rising edge
- arst_ni  in  1  asynchronous, active-low reset
- irq_i  in  VECTORS  level interrupt requests
- instrBoundary_i  in  1  core may be interrupted this cycle
- reti_i  in  1  RETI decoded; single-cycle pulse, only at a boundary
- psw_i  in  WORD  current status word (status register data output)
- ie_i, slp_i  in  1 each  status register IE / SLP bits
- pc_i, sp_i  in  WORD  current PC / SP
- busy_o  out  1  sequencer active; core stalls
- irqAck_o  out  VECTORS  one-hot acknowledge pulse
- srWrEn_o, srClrSlp_o, srSetPriv_o  out  1 each  status register strobes
- srWrMode_o  out  WORD/8  byte enables for srWrEn_o
- srData_o  out  WORD  status register write data
- srPriv_o  out  PRIVW  privilege for srSetPriv_o
- pcWr_o, spWr_o  out  1 each  PC / SP load strobes
- pcData_o, spData_o  out  WORD  PC / SP load values
- memReq_o, memWr_o  out  1 each  memory request, write select
- memAddr_o, memWData_o  out  WORD  address, write data
- memAck_i  in  1  request completes at this clock edge
- memRData_i  in  WORD  read data, valid with memAck_i

## Operation
- States: IDLE, PUSH_PC, PUSH_PSW, FETCH_VEC, SR_CLR, SET_PRIV, POP_PSW, POP_PC, RESTORE.
- IDLE → POP_PSW when reti_i=1.
  - reti_i has priority over irq in the same cycle; the irq stays pending (level) and is taken after RESTORE.
- IDLE → PUSH_PC when instrBoundary_i=1, ie_i=1, |irq_i=1.
  - Latch the lowest set index, sp_i, pc_i and psw_i.
- PUSH_PC: write latched PC to SP-2. PUSH_PSW: write latched PSW to SP-4.
- FETCH_VEC: read VECBASE+2·idx and latch the result as the handler address.
- SR_CLR: one cycle.
  - srWrEn_o=1, srWrMode_o=2'b01, srData_o = latched PSW with IE=0 and SLP=0 (flags preserved).
  - spWr_o=1, spData_o=SP-4.
- SET_PRIV: one cycle.
  - srSetPriv_o=1, srPriv_o=HANDLER_PRIV.
  - pcWr_o=1, pcData_o=handler address.
  - irqAck_o[idx]=1. → IDLE.
- POP_PSW: read SP and latch. POP_PC: read SP+2 and latch.
- RESTORE: one cycle.
  - srWrEn_o=1, srWrMode_o=2'b11, srData_o = popped PSW.
  - pcWr_o=1 with popped PC; spWr_o=1 with SP+4. → IDLE.
- Memory states hold memReq_o and all memory outputs stable until memAck_i. Advance on the edge where memAck_i=1.
- Address arithmetic is mod 2^WORD: SP=0x0000 pushes to 0xFFFE/0xFFFC; SP=0xFFFC pops wrap to 0x0000.
- srWrEn_o and srSetPriv_o are never asserted in the same cycle.
- irq_i deasserting mid-entry does not abort; the latched index is used.
- busy_o=1 in every state except IDLE.

## Timing
- Reset (arst_ni=0): state IDLE, all outputs 0, latches cleared; takes effect immediately and aborts any sequence mid-operation.
- Entry latency with memAck_i tied high: accept edge + 5 cycles (PUSH_PC, PUSH_PSW, FETCH_VEC, SR_CLR, SET_PRIV). Each memory wait cycle adds 1.
- RETI latency with memAck_i tied high: 3 cycles.
- All strobe outputs are single-cycle and registered-state decoded (Moore); no input-to-output combinational paths except through state.

## Configuration
- SLEEP_WAKE_EN defined: in IDLE with slp_i=1, ie_i=0 and |irq_i=1, pulse srClrSlp_o for one cycle. No entry or ack occurs, and the core resumes.
- SLEEP_WAKE_EN not defined: srClrSlp_o is tied 0. A sleeping core wakes only through a taken interrupt (IE=1), whose SR_CLR write clears SLP.

## Test plan
- Entry: SP=0x0800, PC=0x1234, PSW=0x002F, irq_i=8'b0000_0100, memAck_i=1, vector entry 2 = 0x4000.
  - Expect writes 0x1234@0x07FE and 0x002F@0x07FC, then read 0xFFC4.
  - Expect srData_o=0x000F, mode 01; SP=0x07FC; priv 0; PC=0x4000; irqAck_o=0x04.
- RETI: SP=0x07FC, memory holds 0x002F/0x1234.
  - Expect reads 0x07FC then 0x07FE; srData_o=0x002F, mode 11; PC=0x1234; SP=0x0800.
- Priority and collision: irq_i=0x81 with reti_i=1 in the same cycle → RETI runs first, then vector 0 is taken.
- Wait states: memAck_i delayed 3 cycles per access → memAddr_o/memWData_o stable throughout; entry takes 14 cycles.
- Wrap and masking: SP=0x0000 → pushes go to 0xFFFE/0xFFFC. ie_i=0 → no entry.
  - With SLEEP_WAKE_EN and slp_i=1: a single srClrSlp_o pulse.
- Reset mid-sequence: drop arst_ni in FETCH_VEC → all outputs 0 immediately; returns to IDLE.
